// File: rtl/mul_pp_iter_if.sv
//------------------------------------------------------------------------------
// mul_pp_iter_if
// Request/result bundle between the issue logic, the iterative partial-product
// stage and the multiplier finish stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mul_pp_iter_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        en;
  logic        sign;
  logic        upper;
  logic [9:0]  rs1_u_end;
  logic [9:0]  rs2_u_end;
  logic [63:0] sum;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, en, sign, upper, rs1_u_end, rs2_u_end, sum
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, en, sign, upper, rs1_u_end, rs2_u_end, sum
  );
endinterface

`default_nettype wire

// File: rtl/mul_pp_iter.sv
//------------------------------------------------------------------------------
// mul_pp_iter
// Iterative partial-product stage of the M-extension multiplier. Accumulates
// every partial product except rs1_mag[9:0] x rs2_mag[31:22], which is left to
// the finish stage together with the sign fix-up and word select.
// Optional feature macro: MUL_ZERO_SKIP_EN (zero operand goes straight to DONE).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_pp_iter #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_pp_iter_if.slave  pp_if
);

  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bpc_illegal
      $error("mul_pp_iter: BITS_PER_CYCLE must be 1 or 2");
    end
  endgenerate

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_ph_a = 2'd1;
  localparam logic [1:0] c_st_ph_b = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [4:0] c_a_last = 5'(22 / BITS_PER_CYCLE - 1);
  localparam logic [4:0] c_b_last = 5'(10 / BITS_PER_CYCLE - 1);

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [21:0] r_rs1_hi;
  logic [9:0]  r_rs1_tail;
  logic [9:0]  r_rs2_tail;
  logic        r_sign_int;
  logic        r_upper_int;

  logic [63:0] r_sum;
  logic [9:0]  r_rs1_u_end;
  logic [9:0]  r_rs2_u_end;
  logic        r_sign;
  logic        r_upper;

  logic        w_rs1_signed;
  logic        w_rs2_signed;
  logic        w_rs1_neg;
  logic        w_rs2_neg;
  logic [31:0] w_rs1_mag;
  logic [31:0] w_rs2_mag;
  logic        w_zero;
  logic        w_sign;
  logic        w_upper;
  logic [63:0] w_addend;
  logic [63:0] w_acc_next;

  always_comb begin
    w_rs1_signed = (pp_if.funct3 == 3'b001) || (pp_if.funct3 == 3'b010);
    w_rs2_signed = (pp_if.funct3 == 3'b001);
    w_rs1_neg    = w_rs1_signed && pp_if.rs1[31];
    w_rs2_neg    = w_rs2_signed && pp_if.rs2[31];
    w_rs1_mag    = w_rs1_neg ? (~pp_if.rs1 + 32'd1) : pp_if.rs1;
    w_rs2_mag    = w_rs2_neg ? (~pp_if.rs2 + 32'd1) : pp_if.rs2;
    w_zero       = (w_rs1_mag == 32'd0) || (w_rs2_mag == 32'd0);
    // A zero product is reported as +0 with empty tails on every build.
    w_sign       = (w_rs1_neg ^ w_rs2_neg) && !w_zero;
    w_upper      = (pp_if.funct3 != 3'b000);
  end

  // r_mcand is pre-shifted to the weight of r_mplier[0]; add the next bits.
  always_comb begin
    w_addend = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) begin
        w_addend = w_addend + (r_mcand << i);
      end
    end
    w_acc_next = r_acc + w_addend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rs1_hi    <= '0;
      r_rs1_tail  <= '0;
      r_rs2_tail  <= '0;
      r_sign_int  <= 1'b0;
      r_upper_int <= 1'b0;
      r_sum       <= '0;
      r_rs1_u_end <= '0;
      r_rs2_u_end <= '0;
      r_sign      <= 1'b0;
      r_upper     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (pp_if.start && !pp_if.flush) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= {32'd0, w_zero ? 32'd0 : w_rs1_mag};
            r_mplier    <= w_zero ? 32'd0 : w_rs2_mag;
            r_rs1_hi    <= w_zero ? 22'd0 : w_rs1_mag[31:10];
            r_rs1_tail  <= w_zero ? 10'd0 : w_rs1_mag[9:0];
            r_rs2_tail  <= w_zero ? 10'd0 : w_rs2_mag[31:22];
            r_sign_int  <= w_sign;
            r_upper_int <= w_upper;
`ifdef MUL_ZERO_SKIP_EN
            if (w_zero) begin
              r_state     <= c_st_done;
              r_sum       <= '0;
              r_rs1_u_end <= '0;
              r_rs2_u_end <= '0;
              r_sign      <= 1'b0;
              r_upper     <= w_upper;
            end else begin
              r_state <= c_st_ph_a;
            end
`else
            r_state <= c_st_ph_a;
`endif
          end
        end

        c_st_ph_a: begin
          if (pp_if.flush) begin
            r_state <= c_st_idle;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            if (r_cnt == c_a_last) begin
              // r_mplier[0] now holds rs2 bit 22, whose weight is 2^32 for rs1[31:10].
              r_cnt   <= '0;
              r_mcand <= {10'd0, r_rs1_hi, 32'd0};
              r_state <= c_st_ph_b;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end

        c_st_ph_b: begin
          if (pp_if.flush) begin
            r_state <= c_st_idle;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            if (r_cnt == c_b_last) begin
              r_cnt       <= '0;
              r_state     <= c_st_done;
              r_sum       <= w_acc_next;
              r_rs1_u_end <= r_rs1_tail;
              r_rs2_u_end <= r_rs2_tail;
              r_sign      <= r_sign_int;
              r_upper     <= r_upper_int;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end

        c_st_done: begin
          r_state <= c_st_idle;
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign pp_if.busy      = (r_state != c_st_idle);
  assign pp_if.en        = (r_state == c_st_done);
  assign pp_if.sign      = r_sign;
  assign pp_if.upper     = r_upper;
  assign pp_if.rs1_u_end = r_rs1_u_end;
  assign pp_if.rs2_u_end = r_rs2_u_end;
  assign pp_if.sum       = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_mul_pp_iter.sv
//------------------------------------------------------------------------------
// tb_mul_pp_iter
// Scoreboard bench driving a BITS_PER_CYCLE=2 and a BITS_PER_CYCLE=1 instance
// with the same requests, checking results, tails, flags and EN timing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mul_pp_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_pp_iter_if bus2();
  mul_pp_iter_if bus1();

  assign bus1.start  = bus2.start;
  assign bus1.funct3 = bus2.funct3;
  assign bus1.rs1    = bus2.rs1;
  assign bus1.rs2    = bus2.rs2;
  assign bus1.flush  = bus2.flush;

  mul_pp_iter #(.BITS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .pp_if(bus2));
  mul_pp_iter #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .pp_if(bus1));

  typedef struct {
    logic [63:0] sum;
    logic [9:0]  t1;
    logic [9:0]  t2;
    logic        sign;
    logic        upper;
    logic [63:0] word;
    int          en_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: spec-level SUM/tails/flags plus the full product word.
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, input int now);
    exp_t        e;
    logic        s1, s2, n1, n2;
    logic [31:0] m1, m2;
    logic [63:0] x1, x2, prod;
    s1 = (f == 3'b001) || (f == 3'b010);
    s2 = (f == 3'b001);
    n1 = s1 && a[31];
    n2 = s2 && b[31];
    m1 = n1 ? (~a + 32'd1) : a;
    m2 = n2 ? (~b + 32'd1) : b;
    e.sum   = ({32'd0, m1} * {42'd0, m2[21:0]}) + (({42'd0, m1[31:10]} * {54'd0, m2[31:22]}) << 32);
    e.t1    = m1[9:0];
    e.t2    = m2[31:22];
    e.sign  = n1 ^ n2;
    e.upper = (f != 3'b000);
    if (m1 == 32'd0 || m2 == 32'd0) begin
      e.sign = 1'b0;
      e.t1   = '0;
      e.t2   = '0;
    end
    x1   = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    x2   = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    prod = x1 * x2;
    e.word    = (f == 3'b000) ? {32'd0, prod[31:0]} : {32'd0, prod[63:32]};
    e.en_cyc  = now + lat;
    e.chk_lat = 1'b1;
`ifdef MUL_ZERO_SKIP_EN
    if (m1 == 32'd0 || m2 == 32'd0) e.chk_lat = 1'b0;
`endif
    return e;
  endfunction

  task automatic score(input string dn, input exp_t e, input int now, input logic [63:0] sum,
                       input logic [9:0] t1, input logic [9:0] t2, input logic sg, input logic up);
    logic [63:0] full;
    if (e.chk_lat) check_val({dn, "_latency_cyc"}, 64'(now), 64'(e.en_cyc));
    check_val({dn, "_sum"}, sum, e.sum);
    check_val({dn, "_rs1_u_end"}, {54'd0, t1}, {54'd0, e.t1});
    check_val({dn, "_rs2_u_end"}, {54'd0, t2}, {54'd0, e.t2});
    check_val({dn, "_sign"}, {63'd0, sg}, {63'd0, e.sign});
    check_val({dn, "_upper"}, {63'd0, up}, {63'd0, e.upper});
    full = sum + (({54'd0, t1} * {54'd0, t2}) << 22);
    if (sg) full = ~full + 64'd1;
    check_val({dn, "_finish_word"}, up ? {32'd0, full[63:32]} : {32'd0, full[31:0]}, e.word);
  endtask

  always @(negedge clk) begin
    if (bus2.en) begin
      if (q2.size() == 0) check_val("dut2_unexpected_en", {63'd0, bus2.en}, 64'd0);
      else score("dut2", q2.pop_front(), cyc, bus2.sum, bus2.rs1_u_end, bus2.rs2_u_end, bus2.sign, bus2.upper);
    end
  end

  always @(negedge clk) begin
    if (bus1.en) begin
      if (q1.size() == 0) check_val("dut1_unexpected_en", {63'd0, bus1.en}, 64'd0);
      else score("dut1", q1.pop_front(), cyc, bus1.sum, bus1.rs1_u_end, bus1.rs2_u_end, bus1.sign, bus1.upper);
    end
  end

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus2.funct3 = f;
    bus2.rs1    = a;
    bus2.rs2    = b;
    bus2.start  = 1'b1;
    if (push) begin
      q2.push_back(model(f, a, b, 17, cyc));
      q1.push_back(model(f, a, b, 33, cyc));
    end
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q2.size() != 0 || q1.size() != 0 || bus2.busy || bus1.busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_val("timeout_pending", 64'(q2.size() + q1.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string dn, input logic busy, input logic en, input logic sg, input logic up,
                            input logic [9:0] t1, input logic [9:0] t2, input logic [63:0] sum);
    check_val({dn, "_busy_zero"}, {63'd0, busy}, 64'd0);
    check_val({dn, "_en_zero"}, {63'd0, en}, 64'd0);
    check_val({dn, "_sign_zero"}, {63'd0, sg}, 64'd0);
    check_val({dn, "_upper_zero"}, {63'd0, up}, 64'd0);
    check_val({dn, "_rs1_u_end_zero"}, {54'd0, t1}, 64'd0);
    check_val({dn, "_rs2_u_end_zero"}, {54'd0, t2}, 64'd0);
    check_val({dn, "_sum_zero"}, sum, 64'd0);
  endtask

  initial begin
    logic [63:0] prev_sum;
    bus2.start  = 1'b0;
    bus2.flush  = 1'b0;
    bus2.funct3 = 3'b000;
    bus2.rs1    = '0;
    bus2.rs2    = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst2", bus2.busy, bus2.en, bus2.sign, bus2.upper, bus2.rs1_u_end, bus2.rs2_u_end, bus2.sum);
    check_zero("rst1", bus1.busy, bus1.en, bus1.sign, bus1.upper, bus1.rs1_u_end, bus1.rs2_u_end, bus1.sum);
    rst_n = 1'b1;
    @(negedge clk);

    drive_start(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle();
    check_val("mulhu_sum_const", bus2.sum, 64'hFFFF_FBFF_FFC0_0001);

    drive_start(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1);
    wait_idle();
    check_val("mulh_sum_const", bus2.sum, 64'h6);

    drive_start(3'b010, 32'h8000_0000, 32'h8000_0000, 1);
    wait_idle();
    check_val("mulhsu_sum_const", bus2.sum, 64'h4000_0000_0000_0000);

    // A second request while busy must be dropped.
    drive_start(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    repeat (4) @(negedge clk);
    drive_start(3'b011, 32'h0000_1111, 32'h0000_2222, 0);
    wait_idle();
    prev_sum = bus2.sum;

    // Flush in PH_A: no EN, outputs hold.
    drive_start(3'b001, 32'h0BAD_F00D, 32'h0000_0055, 0);
    repeat (5) @(negedge clk);
    bus2.flush = 1'b1;
    @(negedge clk);
    bus2.flush = 1'b0;
    check_val("flush_busy2", {63'd0, bus2.busy}, 64'd0);
    check_val("flush_busy1", {63'd0, bus1.busy}, 64'd0);
    check_val("flush_sum_hold", bus2.sum, prev_sum);
    drive_start(3'b011, 32'd7, 32'd6, 1);
    wait_idle();
    check_val("after_flush_sum", bus2.sum, 64'd42);

    // Reset mid-operation.
    drive_start(3'b001, 32'hDEAD_BEEF, 32'h0001_2345, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst2", bus2.busy, bus2.en, bus2.sign, bus2.upper, bus2.rs1_u_end, bus2.rs2_u_end, bus2.sum);
    check_zero("midrst1", bus1.busy, bus1.en, bus1.sign, bus1.upper, bus1.rs1_u_end, bus1.rs2_u_end, bus1.sum);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // START together with FLUSH in IDLE is dropped.
    bus2.flush = 1'b1;
    drive_start(3'b011, 32'd3, 32'd5, 0);
    bus2.flush = 1'b0;
    check_val("start_flush_idle_busy", {63'd0, bus2.busy}, 64'd0);

    drive_start(3'b001, 32'd0, 32'hFFFF_FFFF, 1);
    wait_idle();
    check_val("zero_op_sum", bus2.sum, 64'd0);
    check_val("zero_op_sign", {63'd0, bus2.sign}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      drive_start(3'($urandom_range(0, 7)), $urandom, $urandom, 1);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
